// File: rtl/magnitude_compare_pipe.sv
// -----------------------------------------------------------------------------
// magnitude_compare_pipe
//   Pipelined magnitude comparator for the FPU datapath. Compares A and B as
//   unsigned, two's-complement signed or sign-magnitude float and returns a
//   one-hot {lt, eq, gt, unord} result, STAGES cycles after acceptance.
//   Valid/ready handshake on both sides, full throughput, lossless stalls.
//
//   Optional feature macro: CMP_FP_NAN_EN
//     defined   -> float mode flags NaN operands as unordered (unord=1)
//     undefined -> unord tied 0, NaN bit patterns ordered as plain values
//
//   Stage 1 captures a/b/mode. The compare core sits between stage 1 and
//   stage 2; later stages only carry the 4-bit result. With STAGES=1 the
//   result is decoded directly from the stage-1 registers.
//   Parameter limits: WIDTH >= 4, 1 <= EXP_W <= WIDTH-2, 1 <= STAGES <= 4.
// -----------------------------------------------------------------------------
module magnitude_compare_pipe #(
   parameter int WIDTH  = 32,
   parameter int EXP_W  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             lt,
   output logic             eq,
   output logic             gt,
   output logic             unord
);

   localparam int MANT_W = WIDTH - 1 - EXP_W;

`ifdef CMP_FP_NAN_EN
   localparam bit NAN_EN = 1'b1;
`else
   localparam bit NAN_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      MODE_UNS = 2'b00,
      MODE_SGN = 2'b01,
      MODE_FLT = 2'b10,
      MODE_RSV = 2'b11
   } cmp_mode_e;

   // NaN: exponent all ones with a non-zero mantissa
   function automatic logic is_nan(input logic [WIDTH-1:0] x);
      return (&x[WIDTH-2 -: EXP_W]) && (|x[MANT_W-1:0]);
   endfunction

   // Full compare: returns {lt, eq, gt, unord}
   function automatic logic [3:0] cmp_fn(
      input logic [WIDTH-1:0] a_i,
      input logic [WIDTH-1:0] b_i,
      input logic [1:0]       mode_i
   );
      logic [WIDTH-1:0] diff;
      logic [WIDTH-1:0] pre;
      logic [WIDTH-1:0] top;
      logic             raw_lt;
      logic             raw_eq;
      logic             sa;
      logic             sb;
      logic             both_zero;
      logic             lt_v;
      logic             eq_v;
      logic             gt_v;
      logic             unord_v;

      // Log-depth prefix OR from the MSB down: pre[i] = |diff[WIDTH-1:i]
      diff = a_i ^ b_i;
      pre  = diff;
      for (int s = 1; s < WIDTH; s = s * 2) begin
         pre = pre | (pre >> s);
      end
      // Isolate the highest differing bit; a<b iff b owns the 1 there
      top    = pre & ~(pre >> 1);
      raw_lt = |(top & ~a_i & b_i);
      raw_eq = ~|diff;

      sa        = a_i[WIDTH-1];
      sb        = b_i[WIDTH-1];
      both_zero = ~|a_i[WIDTH-2:0] && ~|b_i[WIDTH-2:0];

      lt_v    = raw_lt;
      eq_v    = raw_eq;
      gt_v    = !raw_lt && !raw_eq;
      unord_v = 1'b0;

      case (cmp_mode_e'(mode_i))
         MODE_SGN: begin
            if (sa != sb) begin
               lt_v = sa;
               eq_v = 1'b0;
               gt_v = sb;
            end
         end
         MODE_FLT: begin
            if (NAN_EN && (is_nan(a_i) || is_nan(b_i))) begin
               lt_v    = 1'b0;
               eq_v    = 1'b0;
               gt_v    = 1'b0;
               unord_v = 1'b1;
            end else if (both_zero) begin
               // +0 and -0 are equal
               lt_v = 1'b0;
               eq_v = 1'b1;
               gt_v = 1'b0;
            end else if (sa != sb) begin
               lt_v = sa;
               eq_v = 1'b0;
               gt_v = sb;
            end else if (sa) begin
               // Both negative: larger magnitude is the smaller value
               lt_v = !raw_lt && !raw_eq;
               gt_v = raw_lt;
            end
         end
         default: begin
            // Unsigned and reserved mode share the raw result
         end
      endcase

      return {lt_v, eq_v, gt_v, unord_v};
   endfunction

   logic [STAGES:1]  r_valid;
   logic [STAGES:1]  w_load;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [1:0]       r_mode;
   logic [3:0]       w_res;

   // Backpressure chain: a stage may load when empty or when it is draining
   // NOTE: every comb output gets a default first, so no path leaves a latch.
   always_comb begin
      logic v_ok;
      w_load = '0;
      v_ok   = out_ready;
      for (int k = STAGES; k >= 1; k--) begin
         w_load[k] = !r_valid[k] || v_ok;
         v_ok      = w_load[k];
      end
   end

   assign in_ready = w_load[1];

   // Stage valid bits; reset empties the pipe and drops in-flight work
   // NOTE: sequential state uses non-blocking assignments so every stage
   // samples its predecessor's pre-edge value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
      end else begin
         if (w_load[1]) r_valid[1] <= in_valid;
         for (int k = 2; k <= STAGES; k++) begin
            if (w_load[k]) r_valid[k] <= r_valid[k-1];
         end
      end
   end

   // Stage-1 operand capture
   // NOTE: datapath registers carry no reset; outputs are qualified by the
   // valid bits, so their contents are irrelevant while a stage is empty.
   always_ff @(posedge clk) begin
      if (w_load[1] && in_valid) begin
         r_a    <= a;
         r_b    <= b;
         r_mode <= mode;
      end
   end

   generate
      if (STAGES > 1) begin : g_res_pipe
         logic [3:0] r_res [2:STAGES];

         // Result pipeline: compare into stage 2, then shift toward the output
         always_ff @(posedge clk) begin
            if (w_load[2]) r_res[2] <= cmp_fn(r_a, r_b, r_mode);
            for (int k = 3; k <= STAGES; k++) begin
               if (w_load[k]) r_res[k] <= r_res[k-1];
            end
         end

         assign w_res = r_res[STAGES];
      end else begin : g_res_direct
         assign w_res = cmp_fn(r_a, r_b, r_mode);
      end
   endgenerate

   assign out_valid              = r_valid[STAGES];
   assign {lt, eq, gt, unord}    = out_valid ? w_res : 4'b0000;

endmodule

// File: tb/tb_magnitude_compare_pipe.sv
// -----------------------------------------------------------------------------
// tb_magnitude_compare_pipe
//   Self-checking bench for magnitude_compare_pipe (WIDTH=32, EXP_W=8,
//   STAGES=2). Expected results come from a vector table or from an
//   independent order-key model and travel through a scoreboard queue.
//   Honours CMP_FP_NAN_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_magnitude_compare_pipe;

   localparam int WIDTH  = 32;
   localparam int EXP_W  = 8;
   localparam int STAGES = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  a;
   logic [WIDTH-1:0]  b;
   logic [1:0]        mode;
   logic              out_valid;
   logic              out_ready;
   logic              lt;
   logic              eq;
   logic              gt;
   logic              unord;

   always #5 clk = ~clk;

   magnitude_compare_pipe #(
      .WIDTH  (WIDTH),
      .EXP_W  (EXP_W),
      .STAGES (STAGES)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .lt        (lt),
      .eq        (eq),
      .gt        (gt),
      .unord     (unord)
   );

   typedef struct packed {
      logic [3:0]  res;
      int unsigned cyc;
      logic        lat_chk;
   } sb_t;

   typedef struct {
      logic [31:0] va;
      logic [31:0] vb;
      logic [1:0]  vm;
      logic [3:0]  exp;
   } vec_t;

   sb_t         sb_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int unsigned cyc      = 0;
   int          pops     = 0;
   logic        mon_en   = 1'b0;
   logic [3:0]  cur_exp  = 4'b0;
   logic        cur_lat  = 1'b0;
   logic        held_v   = 1'b0;
   logic [3:0]  held     = 4'b0;
   logic        saw_bp   = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Independent reference: map each operand to an unsigned order key
   function automatic logic [31:0] fkey(input logic [31:0] x);
      if (x[30:0] == 31'd0) return 32'h8000_0000;
      if (x[31])            return ~x;
      return x | 32'h8000_0000;
   endfunction

   function automatic logic fnan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
   endfunction

   function automatic logic [3:0] model(input logic [31:0] ma, input logic [31:0] mb, input logic [1:0] mm);
      logic [31:0] ka;
      logic [31:0] kb;
      if (mm == 2'b01) begin
         if ($signed(ma) < $signed(mb)) return 4'b1000;
         if (ma == mb)                  return 4'b0100;
         return 4'b0010;
      end
      if (mm == 2'b10) begin
`ifdef CMP_FP_NAN_EN
         if (fnan(ma) || fnan(mb)) return 4'b0001;
`endif
         ka = fkey(ma);
         kb = fkey(mb);
      end else begin
         ka = ma;
         kb = mb;
      end
      if (ka < kb)  return 4'b1000;
      if (ka == kb) return 4'b0100;
      return 4'b0010;
   endfunction

   always @(posedge clk) cyc++;

   // Output monitor + scoreboard push, evaluated half a cycle from the edge
   always @(negedge clk) begin
      logic [3:0] got;
      sb_t        e;
      if (mon_en) begin
         got = {lt, eq, gt, unord};
         if (out_valid) begin
            if (held_v) check("stall_hold", got, held);
            if (out_ready) begin
               held_v = 1'b0;
               if (sb_q.size() == 0) begin
                  check("unexpected_output", out_valid, 0);
               end else begin
                  e = sb_q.pop_front();
                  check("result", got, e.res);
                  if (e.lat_chk) check("latency", cyc - e.cyc, STAGES);
                  pops++;
               end
            end else begin
               held_v = 1'b1;
               held   = got;
            end
         end else begin
            held_v = 1'b0;
            check("idle_zero", got, 0);
         end
         if (in_valid && in_ready)  sb_q.push_back('{res: cur_exp, cyc: cyc, lat_chk: cur_lat});
         if (in_valid && !in_ready) saw_bp = 1'b1;
      end
   end

   // Present one transaction and hold it until accepted; returns at edge+1
   task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic [1:0] vm,
                       input logic [3:0] ve, input logic vl);
      int   guard;
      logic done;
      a        = va;
      b        = vb;
      mode     = vm;
      cur_exp  = ve;
      cur_lat  = vl;
      in_valid = 1'b1;
      guard    = 0;
      done     = 1'b0;
      while (!done) begin
         @(negedge clk);
         if (in_ready) done = 1'b1;
         guard++;
         if (!done && guard > 100) begin
            check("accept_timeout", 0, 1);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int guard;
      out_ready = 1'b1;
      guard     = 0;
      while (sb_q.size() != 0 && guard < 200) begin
         @(posedge clk);
         #1;
         guard++;
      end
      check("drain_empty", sb_q.size(), 0);
   endtask

   vec_t        vecs[$];
   logic        rand_done;
   int          pops_before;
   logic [31:0] ra;
   logic [31:0] rb;
   logic [1:0]  rm;

   initial begin
      // Vector table: {a, b, mode, expected {lt,eq,gt,unord}}
      vecs.push_back('{32'h0000_0001, 32'hFFFF_FFFF, 2'b00, 4'b1000});
      vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 2'b01, 4'b1000});
      vecs.push_back('{32'h8000_0000, 32'h8000_0000, 2'b01, 4'b0100});
      vecs.push_back('{32'h8000_0000, 32'h0000_0000, 2'b10, 4'b0100});
      vecs.push_back('{32'hC000_0000, 32'hBF80_0000, 2'b10, 4'b1000});
      vecs.push_back('{32'h7F80_0000, 32'h7F7F_FFFF, 2'b10, 4'b0010});
`ifdef CMP_FP_NAN_EN
      vecs.push_back('{32'h7FC0_0000, 32'h3F80_0000, 2'b10, 4'b0001});
      vecs.push_back('{32'h7FC0_0000, 32'h7FC0_0000, 2'b10, 4'b0001});
      vecs.push_back('{32'hFFC0_0000, 32'h0000_0000, 2'b10, 4'b0001});
`else
      vecs.push_back('{32'h7FC0_0000, 32'h3F80_0000, 2'b10, 4'b0010});
      vecs.push_back('{32'h7FC0_0000, 32'h7FC0_0000, 2'b10, 4'b0100});
      vecs.push_back('{32'hFFC0_0000, 32'h0000_0000, 2'b10, 4'b1000});
`endif
      vecs.push_back('{32'h0000_0001, 32'hFFFF_FFFF, 2'b11, 4'b1000});
      vecs.push_back('{32'h7FFF_FFFF, 32'h8000_0000, 2'b01, 4'b0010});
      vecs.push_back('{32'h8000_0000, 32'h7FFF_FFFF, 2'b00, 4'b0010});
      vecs.push_back('{32'h0000_0000, 32'h0000_0001, 2'b00, 4'b1000});
      vecs.push_back('{32'h1234_5678, 32'h1234_5678, 2'b00, 4'b0100});
      vecs.push_back('{32'hBF80_0000, 32'h3F80_0000, 2'b10, 4'b1000});
      vecs.push_back('{32'hFF80_0000, 32'h7F80_0000, 2'b10, 4'b1000});
      vecs.push_back('{32'h3F80_0000, 32'h4000_0000, 2'b10, 4'b1000});
      vecs.push_back('{32'h0000_0000, 32'h8000_0001, 2'b10, 4'b0010});

      // Reset state
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      mode      = 2'b00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_out_valid", out_valid, 0);
      check("reset_results", {lt, eq, gt, unord}, 0);
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);
      check("reset_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      // Table vectors back-to-back with out_ready held high: latency checked
      for (int i = 0; i < vecs.size(); i++) begin
         send(vecs[i].va, vecs[i].vb, vecs[i].vm, vecs[i].exp, 1'b1);
      end
      idle();
      drain();

      // Six back-to-back transactions, downstream stalled for cycles 3..5
      saw_bp      = 1'b0;
      pops_before = pops;
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               ra = 32'h3F80_0000 + 32'(i * 32'h0080_0000);
               rb = 32'h4000_0000;
               send(ra, rb, 2'b10, model(ra, rb, 2'b10), 1'b0);
            end
            idle();
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();
      check("stall_in_ready_dropped", saw_bp, 1);
      check("stall_result_count", pops - pops_before, 6);

      // Random operands with random downstream backpressure
      rand_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 60; i++) begin
               ra = $urandom;
               case ($urandom_range(0, 3))
                  0:       rb = ra;
                  1:       rb = ra ^ 32'h8000_0000;
                  2:       rb = ra ^ (32'h1 << $urandom_range(0, 31));
                  default: rb = $urandom;
               endcase
               rm = 2'($urandom_range(0, 3));
               send(ra, rb, rm, model(ra, rb, rm), 1'b0);
            end
            idle();
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      drain();

      // Reset with two transactions in flight
      out_ready = 1'b0;
      send(32'h0000_0005, 32'h0000_0003, 2'b00, 4'b0010, 1'b0);
      send(32'h0000_0003, 32'h0000_0005, 2'b00, 4'b1000, 1'b0);
      idle();
      rst_n = 1'b0;
      @(negedge clk);
      check("midreset_out_valid", out_valid, 0);
      check("midreset_results", {lt, eq, gt, unord}, 0);
      sb_q.delete();
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("no_stale_after_reset", out_valid, 0);
      end
      @(posedge clk);
      #1;
      send(32'h0000_0001, 32'hFFFF_FFFF, 2'b00, 4'b1000, 1'b1);
      idle();
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

endmodule
